// File: rtl/cb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cb_pkg
//  Purpose  : Shared constants and scan-state encoding for the covariance-block
//             scan engine (cb_scan) and its tag pipeline (cb_tag_pipe).
//  Contents : CB_AW   - covariance-block address width
//             ROW_LEN - row/column coordinate width
//             AGD_LAT - address-generator latency, request to address
//             scan_state_t - IDLE / SCAN / DRAIN
//  Revision : 1.0 - initial release
// ============================================================================
package cb_pkg;

  localparam int CB_AW   = 19;
  localparam int ROW_LEN = 10;
  localparam int AGD_LAT = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2
  } scan_state_t;

endpackage : cb_pkg
`default_nettype wire

// File: rtl/cb_tag_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : cb_tag_pipe
//  Purpose  : DEPTH-stage shift register carrying {valid, row, col, last} for
//             each request so the tag lines up with the address returned by
//             the address generator DEPTH cycles later.
//  Ports    : clk, rst (async, active-high)
//             in_valid/in_row/in_col/in_last   - tag entering the pipe
//             out_valid/out_row/out_col/out_last - tag leaving the last stage
//  Revision : 1.0 - initial release
// ============================================================================
module cb_tag_pipe #(
  parameter int W     = 10,
  parameter int DEPTH = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_row,
  input  logic [W-1:0] in_col,
  input  logic         in_last,
  output logic         out_valid,
  output logic [W-1:0] out_row,
  output logic [W-1:0] out_col,
  output logic         out_last
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] last_q;
  logic [W-1:0]     row_q [DEPTH];
  logic [W-1:0]     col_q [DEPTH];

  // Every stage is cleared on reset so a mid-scan reset leaves nothing in
  // flight that could surface as a stray addr_valid afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      last_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        row_q[i] <= '0;
        col_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      last_q[0]  <= in_last;
      row_q[0]   <= in_row;
      col_q[0]   <= in_col;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        last_q[i]  <= last_q[i-1];
        row_q[i]   <= row_q[i-1];
        col_q[i]   <= col_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_last  = last_q[DEPTH-1];
  assign out_row   = row_q[DEPTH-1];
  assign out_col   = col_q[DEPTH-1];

endmodule : cb_tag_pipe
`default_nettype wire

// File: rtl/cb_scan.sv
`default_nettype none
// ============================================================================
//  Module   : cb_scan
//  Purpose  : Walks a rectangular window of covariance-block coordinates in
//             row- or column-major order, issuing one request per cycle to an
//             external fixed-latency address generator, and tags each returned
//             address with the coordinates that produced it.
//  Ports    : clk, sys_rst (async, active-high)
//             start, row_base, col_base, n_rows, n_cols, col_major - scan cmd
//             CB_row, CB_col, req_valid          - request to generator
//             CB_base_addr                       - address from generator
//             addr_valid, addr_row, addr_col, addr_last, out_addr - tagged out
//             busy, done                         - status
//  Revision : 1.0 - initial release
// ============================================================================
module cb_scan #(
  parameter int CB_AW   = cb_pkg::CB_AW,
  parameter int ROW_LEN = cb_pkg::ROW_LEN,
  parameter int AGD_LAT = cb_pkg::AGD_LAT
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               start,
  input  logic [ROW_LEN-1:0] row_base,
  input  logic [ROW_LEN-1:0] col_base,
  input  logic [ROW_LEN-1:0] n_rows,
  input  logic [ROW_LEN-1:0] n_cols,
  input  logic               col_major,
  output logic [ROW_LEN-1:0] CB_row,
  output logic [ROW_LEN-1:0] CB_col,
  output logic               req_valid,
  input  logic [CB_AW-1:0]   CB_base_addr,
  output logic               addr_valid,
  output logic [ROW_LEN-1:0] addr_row,
  output logic [ROW_LEN-1:0] addr_col,
  output logic               addr_last,
  output logic [CB_AW-1:0]   out_addr,
  output logic               busy,
  output logic               done
);
  import cb_pkg::*;

  localparam logic [ROW_LEN-1:0] ONE = ROW_LEN'(1);

  scan_state_t        state, state_nxt;
  logic [ROW_LEN-1:0] row_base_q, col_base_q;
  logic [ROW_LEN-1:0] n_inner_q, n_outer_q;   // loop extents after order swap
  logic [ROW_LEN-1:0] inner_cnt, outer_cnt;
  logic               col_major_q;
  logic               start_ok, inner_end, outer_end, last_req;

  assign start_ok  = start && (n_rows != '0) && (n_cols != '0);
  assign inner_end = (inner_cnt == n_inner_q - ONE);
  assign outer_end = (outer_cnt == n_outer_q - ONE);
  assign last_req  = (state == S_SCAN) && inner_end && outer_end;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_SCAN;
      S_SCAN:  if (last_req) state_nxt = S_DRAIN;
      S_DRAIN: if (done)     state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------- coordinate walker
  // CB_row/CB_col are loaded with the window origin on the accepting edge,
  // so the first request is live in the very next cycle. They are only
  // updated while advancing, which makes them hold after the last request.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      row_base_q  <= '0;
      col_base_q  <= '0;
      n_inner_q   <= '0;
      n_outer_q   <= '0;
      inner_cnt   <= '0;
      outer_cnt   <= '0;
      col_major_q <= 1'b0;
      CB_row      <= '0;
      CB_col      <= '0;
    end else if (state == S_IDLE && start_ok) begin
      row_base_q  <= row_base;
      col_base_q  <= col_base;
      n_inner_q   <= col_major ? n_rows : n_cols;
      n_outer_q   <= col_major ? n_cols : n_rows;
      col_major_q <= col_major;
      inner_cnt   <= '0;
      outer_cnt   <= '0;
      CB_row      <= row_base;
      CB_col      <= col_base;
    end else if (state == S_SCAN && !last_req) begin
      if (inner_end) begin
        inner_cnt <= '0;
        outer_cnt <= outer_cnt + ONE;
        if (col_major_q) begin
          CB_row <= row_base_q;
          CB_col <= CB_col + ONE;
        end else begin
          CB_col <= col_base_q;
          CB_row <= CB_row + ONE;
        end
      end else begin
        inner_cnt <= inner_cnt + ONE;
        if (col_major_q) CB_row <= CB_row + ONE;
        else             CB_col <= CB_col + ONE;
      end
    end
  end

  // Every SCAN cycle carries exactly one request.
  assign req_valid = (state == S_SCAN);

  // ------------------------------------------------------- tag pipe
  cb_tag_pipe #(
    .W     (ROW_LEN),
    .DEPTH (AGD_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (sys_rst),
    .in_valid  (req_valid),
    .in_row    (CB_row),
    .in_col    (CB_col),
    .in_last   (last_req),
    .out_valid (addr_valid),
    .out_row   (addr_row),
    .out_col   (addr_col),
    .out_last  (addr_last)
  );

  assign out_addr = CB_base_addr;
  assign done     = addr_valid && addr_last;
  assign busy     = (state != S_IDLE);

endmodule : cb_scan
`default_nettype wire
